// File: rtl/regfile_multiport.sv
// regfile_multiport: architectural integer register file with NUM_RD combinational read ports,
//   one byte-strobed write port, an optional hardwired-zero entry 0, optional same-cycle
//   write-to-read bypass, and a sequenced clear engine.
// Latency: reads take 0 cycles. A write is stored at the next rising edge and is also visible
//   in the same cycle through bypass. A clear takes exactly DEPTH edges.
// Backpressure: none. A write issued while the clear engine runs is dropped. A clear request
//   issued while a clear is already running is ignored.
// Ports:
//   i_clk, i_rst                  clock and asynchronous active-low reset
//   i_wr_enable/addr/data/strb    write port; strb bit k covers data bits [8k+7:8k]
//   i_rd_addr / o_rd_data         packed read ports; port p uses slice p
//   i_clr_req / o_clr_busy        clear pulse in; clear-engine-running flag out
module regfile_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_enable,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic [DATA_W/8-1:0]      i_wr_strb,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  input  logic                     i_clr_req,
  output logic                     o_clr_busy
);

  localparam int                DEPTH  = 2**ADDR_W;
  localparam int                NBYTES = DATA_W/8;
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH-1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                wr_commit;
  logic [DATA_W-1:0]   wr_merged;

  // wr_merged is the value the addressed entry will hold after the edge. It is shared by
  // the storage update and the bypass path. Writes are blocked while reset is asserted, so
  // bypass cannot leak data onto the read ports during reset.
  always_comb begin
    wr_commit = i_rst && i_wr_enable && (state == IDLE) &&
                !((ZERO_REG != 0) && (i_wr_addr == '0));
    wr_merged = mem[i_wr_addr];
    for (int k = 0; k < NBYTES; k++) begin
      if (i_wr_strb[k]) begin
        wr_merged[8*k +: 8] = i_wr_data[8*k +: 8];
      end
    end
  end

  // Clear engine. o_clr_busy is registered alongside the state, so i_clr_req has no
  // combinational path to any output.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      o_clr_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_clr_req) begin
            state      <= CLEAR;
            cnt        <= '0;
            o_clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt == LAST) begin
            state      <= IDLE;
            cnt        <= '0;
            o_clr_busy <= 1'b0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          o_clr_busy <= 1'b0;
        end
      endcase
    end
  end

  // Storage. A write commits only in IDLE, so it never competes with a clear step.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (wr_commit) begin
      mem[i_wr_addr] <= wr_merged;
    end
  end

  // Read ports. Zero-register masking takes priority over bypass.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = i_rd_addr[p*ADDR_W +: ADDR_W];
    assign o_rd_data[p*DATA_W +: DATA_W] =
        ((ZERO_REG != 0) && (addr == '0))                  ? '0        :
        ((BYPASS != 0) && wr_commit && (i_wr_addr == addr)) ? wr_merged :
                                                              mem[addr];
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: directed bench for regfile_multiport at default parameters.
// Expected values are queued when stimulus is driven and are popped when the DUT output is sampled.
// Inputs are driven 1 ns after a rising edge. Outputs are sampled later in the same cycle.
module tb_regfile_multiport;

  logic        clk;
  logic        rst;
  logic        wr_enable;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        clr_req;
  logic        clr_busy;

  logic [31:0] exp_q [$];
  int          checks;
  int          failures;

  regfile_multiport dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wr_enable (wr_enable),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .i_wr_strb   (wr_strb),
    .i_rd_addr   (rd_addr),
    .o_rd_data   (rd_data),
    .i_clr_req   (clr_req),
    .o_clr_busy  (clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic en, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_enable = en;
    wr_addr   = a;
    wr_data   = d;
    wr_strb   = s;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: observed=%h but scoreboard empty", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    clr_req  = 1'b0;
    wr(1'b1, 5'd5, 32'hFFFF_FFFF, 4'hF);
    set_rd(5'd5, 5'd5);

    // Reads stay 0 during reset, even with a write on the same address.
    #3;
    push(32'h0); push(32'h0); push(32'h0);
    check("rst_busy", {31'b0, clr_busy});
    check("rst_rd0", rd_data[31:0]);
    check("rst_rd1", rd_data[63:32]);
    wr(1'b0, 5'd0, 32'h0, 4'h0);
    #5;
    rst = 1'b1;
    tick();

    // After release, every address reads 0 on both ports.
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a), 5'(31 - a));
      push(32'h0); push(32'h0);
      #1;
      check("init_rd0", rd_data[31:0]);
      check("init_rd1", rd_data[63:32]);
    end
    push(32'h0);
    check("init_busy", {31'b0, clr_busy});

    // Byte-strobed writes, including bypass of each write.
    set_rd(5'd5, 5'd5);
    wr(1'b1, 5'd5, 32'hDEAD_BEEF, 4'hF);
    push(32'hDEAD_BEEF); #1; check("wr_full_bypass", rd_data[31:0]);
    tick();
    wr(1'b1, 5'd5, 32'h1122_3344, 4'h3);
    push(32'hDEAD_3344); #1; check("wr_strb_bypass", rd_data[63:32]);
    tick();
    wr(1'b0, 5'd0, 32'h0, 4'h0);
    push(32'hDEAD_3344); #1; check("wr_strb_stored", rd_data[31:0]);

    // Entry 0 is hardwired to zero, both in the same cycle and after the edge.
    set_rd(5'd0, 5'd0);
    wr(1'b1, 5'd0, 32'hFFFF_FFFF, 4'hF);
    push(32'h0); push(32'h0); #1;
    check("zero_bypass_rd0", rd_data[31:0]);
    check("zero_bypass_rd1", rd_data[63:32]);
    tick();
    wr(1'b0, 5'd0, 32'h0, 4'h0);
    push(32'h0); push(32'h0); #1;
    check("zero_stored_rd0", rd_data[31:0]);
    check("zero_stored_rd1", rd_data[63:32]);

    // Bypass merges strobed bytes with the stored entry. An all-zero strobe is a no-op.
    wr(1'b1, 5'd7, 32'h0000_ABCD, 4'hF);
    tick();
    set_rd(5'd7, 5'd7);
    wr(1'b1, 5'd7, 32'hCAFE_0000, 4'hC);
    push(32'hCAFE_ABCD); push(32'hCAFE_ABCD); #1;
    check("bypass_merge_rd1", rd_data[63:32]);
    check("bypass_merge_rd0", rd_data[31:0]);
    tick();
    wr(1'b1, 5'd7, 32'hFFFF_FFFF, 4'h0);
    push(32'hCAFE_ABCD); #1; check("strb0_bypass", rd_data[63:32]);
    tick();
    wr(1'b0, 5'd0, 32'h0, 4'h0);
    push(32'hCAFE_ABCD); #1; check("strb0_stored", rd_data[31:0]);

    // Fill entries 1..31 with their own index.
    for (int a = 1; a < 32; a++) begin
      wr(1'b1, 5'(a), 32'(a), 4'hF);
      tick();
    end
    wr(1'b0, 5'd0, 32'h0, 4'h0);
    set_rd(5'd20, 5'd31);
    push(32'd20); push(32'd31); #1;
    check("fill_rd0", rd_data[31:0]);
    check("fill_rd1", rd_data[63:32]);

    // Clear, with a write to entry 25 in the request cycle. That write commits.
    wr(1'b1, 5'd25, 32'h0000_AAAA, 4'hF);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    wr(1'b0, 5'd0, 32'h0, 4'h0);
    for (int i = 0; i <= 32; i++) begin
      // Here the clear counter equals i, for i < 32.
      if (i == 5) begin
        wr(1'b1, 5'd3, 32'h0000_FFFF, 4'hF);
        set_rd(5'd3, 5'd3);
        push(32'h0); #1; check("clr_wr_no_bypass", rd_data[31:0]);
      end
      if (i == 6) wr(1'b0, 5'd0, 32'h0, 4'h0);
      if (i == 8) clr_req = 1'b1;
      if (i == 9) clr_req = 1'b0;
      if (i == 10) begin
        set_rd(5'd9, 5'd20);
        push(32'h0); push(32'd20); #1;
        check("mid_clr_addr9", rd_data[31:0]);
        check("mid_clr_addr20", rd_data[63:32]);
        set_rd(5'd25, 5'd3);
        push(32'h0000_AAAA); push(32'h0); #1;
        check("mid_clr_addr25", rd_data[31:0]);
        check("mid_clr_dropped_wr", rd_data[63:32]);
      end
      push(i < 32 ? 32'h1 : 32'h0); #1;
      check("clr_busy", {31'b0, clr_busy});
      tick();
    end
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a), 5'(31 - a));
      push(32'h0); push(32'h0); #1;
      check("post_clr_rd0", rd_data[31:0]);
      check("post_clr_rd1", rd_data[63:32]);
    end

    // Reset in the middle of a clear.
    wr(1'b1, 5'd20, 32'h0000_0055, 4'hF);
    tick();
    wr(1'b1, 5'd30, 32'h0000_1234, 4'hF);
    tick();
    wr(1'b0, 5'd0, 32'h0, 4'h0);
    set_rd(5'd20, 5'd30);
    push(32'h55); push(32'h1234); #1;
    check("pre_rst_rd0", rd_data[31:0]);
    check("pre_rst_rd1", rd_data[63:32]);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (12) tick();
    push(32'h1); check("rst_clr_busy_before", {31'b0, clr_busy});
    #1;
    rst = 1'b0;
    #1;
    push(32'h0); push(32'h0); push(32'h0);
    check("rst_clr_busy", {31'b0, clr_busy});
    check("rst_clr_rd0", rd_data[31:0]);
    check("rst_clr_rd1", rd_data[63:32]);
    #1;
    rst = 1'b1;
    wr(1'b1, 5'd30, 32'h5A5A_5A5A, 4'hF);
    set_rd(5'd30, 5'd30);
    tick();
    wr(1'b0, 5'd0, 32'h0, 4'h0);
    push(32'h5A5A_5A5A); #1; check("post_rst_wr", rd_data[31:0]);
    repeat (3) tick();
    push(32'h0); check("post_rst_no_resume", {31'b0, clr_busy});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
